// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the in-order core.
// Pulses each stage unit in turn, routes by decoded flags, traps/halts/hangs.
module core_sequencer #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        fetch_enabled,
    input  logic        fetch_completed,
    output logic        decode_enabled,
    input  logic        decode_completed,
    output logic        exec_enabled,
    input  logic        exec_completed,
    output logic        mem_enabled,
    input  logic        mem_completed,
    output logic        write_enabled,
    input  logic        write_completed,
    output logic        trap_enabled,
    input  logic        trap_completed,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        rv32a,
    input  logic        writes_to_reg,
    input  logic        exception,
    input  logic        interrupt_pending,
    input  logic        halt_req,
    output logic        halted,
    output logic        hang,
    output logic [63:0] cycle,
    output logic [63:0] instret
);

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WMAX = WW'(TIMEOUT - 1);

    // Stage states come first so the state value doubles as the enable bit index.
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WRITE, S_TRAP, S_HALT, S_HUNG
    } state_t;

    state_t          state_q, state_d;
    logic            issued_q, issued_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [5:0]      en_q, en_d;
    logic            halted_q, halted_d;
    logic            hang_q, hang_d;
    logic            retire;
    logic            done;
    logic            need_mem;
    logic [63:0]     cycle_q;
    logic [63:0]     instret_q;

    assign fetch_enabled  = en_q[0];
    assign decode_enabled = en_q[1];
    assign exec_enabled   = en_q[2];
    assign mem_enabled    = en_q[3];
    assign write_enabled  = en_q[4];
    assign trap_enabled   = en_q[5];
    assign halted         = halted_q;
    assign hang           = hang_q;
    assign cycle          = cycle_q;
    assign instret        = instret_q;
    assign need_mem       = is_load | is_store | rv32a;

    // Next-state, pulse, timeout and retire decisions.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        wcnt_d   = wcnt_q;
        en_d     = '0;
        halted_d = halted_q;
        hang_d   = hang_q;
        retire   = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_FETCH:  done = fetch_completed;
            S_DECODE: done = decode_completed;
            S_EXEC:   done = exec_completed;
            S_MEM:    done = mem_completed;
            S_WRITE:  done = write_completed;
            S_TRAP:   done = trap_completed;
            default:  done = 1'b0;
        endcase
        if (state_q == S_HALT) begin
            if (!halt_req) begin
                halted_d = 1'b0;
                state_d  = S_FETCH;
            end
        end else if (state_q == S_HUNG) begin
            issued_d = 1'b0;
        end else if (!issued_q) begin
            en_d     = 6'(1) << state_q;
            issued_d = 1'b1;
            wcnt_d   = '0;
        end else if (en_q == '0) begin
            if (done) begin
                issued_d = 1'b0;
                unique case (state_q)
                    S_FETCH:  state_d = S_DECODE;
                    S_DECODE: state_d = S_EXEC;
                    S_EXEC: begin
                        if (exception)          state_d = S_TRAP;
                        else if (need_mem)      state_d = S_MEM;
                        else if (writes_to_reg) state_d = S_WRITE;
                        else                    retire  = 1'b1;
                    end
                    S_MEM: begin
                        if (exception)          state_d = S_TRAP;
                        else if (writes_to_reg) state_d = S_WRITE;
                        else                    retire  = 1'b1;
                    end
                    S_WRITE: retire  = 1'b1;
                    default: state_d = S_FETCH;
                endcase
            end else if (wcnt_q == WMAX) begin
                hang_d   = 1'b1;
                issued_d = 1'b0;
                state_d  = S_HUNG;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
        if (retire) begin
            if (halt_req) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
            end else if (interrupt_pending) begin
                state_d = S_TRAP;
            end else begin
                state_d = S_FETCH;
            end
        end
    end

    // Control state, registered outputs and the free-running counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            issued_q  <= 1'b0;
            wcnt_q    <= '0;
            en_q      <= '0;
            halted_q  <= 1'b0;
            hang_q    <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            wcnt_q    <= wcnt_d;
            en_q      <= en_d;
            halted_q  <= halted_d;
            hang_q    <= hang_d;
            cycle_q   <= cycle_q + 64'd1;
            instret_q <= instret_q + {63'd0, retire};
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: stage-unit responders plus an instruction-level
// model of which stage pulses each instruction must produce.
module tb_core_sequencer;

    localparam int TO = 8;
    localparam int F = 0, D = 1, E = 2, M = 3, W = 4, T = 5, H = 6, R = 7;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fetch_enabled, decode_enabled, exec_enabled;
    logic        mem_enabled, write_enabled, trap_enabled;
    logic [5:0]  comp = '0;
    logic        is_load = 1'b0, is_store = 1'b0, rv32a = 1'b0;
    logic        writes_to_reg = 1'b0, exception = 1'b0;
    logic        interrupt_pending = 1'b0, halt_req = 1'b0;
    logic        halted, hang;
    logic [63:0] cycle, instret;
    logic [5:0]  en;

    core_sequencer #(.TIMEOUT(TO)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .fetch_enabled     (fetch_enabled),
        .fetch_completed   (comp[0]),
        .decode_enabled    (decode_enabled),
        .decode_completed  (comp[1]),
        .exec_enabled      (exec_enabled),
        .exec_completed    (comp[2]),
        .mem_enabled       (mem_enabled),
        .mem_completed     (comp[3]),
        .write_enabled     (write_enabled),
        .write_completed   (comp[4]),
        .trap_enabled      (trap_enabled),
        .trap_completed    (comp[5]),
        .is_load           (is_load),
        .is_store          (is_store),
        .rv32a             (rv32a),
        .writes_to_reg     (writes_to_reg),
        .exception         (exception),
        .interrupt_pending (interrupt_pending),
        .halt_req          (halt_req),
        .halted            (halted),
        .hang              (hang),
        .cycle             (cycle),
        .instret           (instret)
    );

    always #5 clk = ~clk;

    assign en = {trap_enabled, write_enabled, mem_enabled,
                 exec_enabled, decode_enabled, fetch_enabled};

    int errors = 0;
    int checks = 0;
    int tcyc = 0;
    int lat[6];
    bit stuck[6];
    int fixlat = 0;
    bit c_ld, c_st, c_a, c_wr, c_irq, c_halt;
    int c_exc = -1;
    int q[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic resp_clear();
        comp = '0;
        exception = 1'b0;
        for (int s = 0; s < 6; s++) lat[s] = -1;
    endtask

    // Each unit clears completed when it sees its pulse and raises it
    // lat cycles later, then holds it (single-cycle style).
    task automatic respond();
        for (int s = 0; s < 6; s++) begin
            if (en[s]) begin
                comp[s] = 1'b0;
                if (stuck[s]) lat[s] = -1;
                else if (fixlat > 0) lat[s] = fixlat;
                else lat[s] = int'($urandom_range(3, 1));
                if (s == F) exception = 1'b0;
                if (s == D) begin
                    is_load = c_ld;
                    is_store = c_st;
                    rv32a = c_a;
                    writes_to_reg = c_wr;
                end
            end else if (lat[s] > 0) begin
                lat[s]--;
                if (lat[s] == 0) begin
                    comp[s] = 1'b1;
                    if (s == c_exc) exception = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        tcyc++;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        resp_clear();
        halt_req = 1'b0;
        interrupt_pending = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        tcyc = 0;
    endtask

    // Choose the next instruction and queue the stage pulses it must cause.
    task automatic plan(input int idx);
        bit m;
        int r;
        c_ld = 0; c_st = 0; c_a = 0; c_wr = 0;
        c_irq = 0; c_halt = 0; c_exc = -1;
        case (idx)
            0: c_st = 1;
            1: begin c_ld = 1; c_wr = 1; c_exc = M; end
            2: begin c_wr = 1; c_irq = 1; c_halt = 1; end
            3: begin c_wr = 1; c_irq = 1; end
            default: begin
                c_ld = 1'($urandom_range(3, 0) == 0);
                c_st = 1'($urandom_range(3, 0) == 0);
                c_a = 1'($urandom_range(5, 0) == 0);
                c_wr = 1'($urandom_range(1, 0));
                c_irq = 1'($urandom_range(3, 0) == 0);
                c_halt = 1'($urandom_range(7, 0) == 0);
                r = int'($urandom_range(7, 0));
                if (r == 0) c_exc = E;
                else if (r == 1 && (c_ld | c_st | c_a)) c_exc = M;
            end
        endcase
        interrupt_pending = c_irq;
        halt_req = c_halt;
        m = c_ld | c_st | c_a;
        q.push_back(D);
        q.push_back(E);
        if (c_exc == E) begin
            q.push_back(T);
        end else begin
            if (m) q.push_back(M);
            if (m && c_exc == M) begin
                q.push_back(T);
            end else begin
                if (c_wr) q.push_back(W);
                q.push_back(R);
                if (c_halt) q.push_back(H);
                else if (c_irq) q.push_back(T);
            end
        end
        q.push_back(F);
    endtask

    initial begin
        int tf[6];
        int tf2, ir11, ir12, s, e, idle, hcnt, ninstr, model_ret, k, late;
        bit in_halt, found;
        for (int i = 0; i < 6; i++) stuck[i] = 0;
        resp_clear();

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_en", en, 0);
        chk("rst_halted", halted, 0);
        chk("rst_hang", hang, 0);
        chk("rst_cycle", cycle, 0);
        chk("rst_instret", instret, 0);

        // ALU op with unit latency: exact pulse cycles.
        do_reset();
        c_ld = 0; c_st = 0; c_a = 0; c_wr = 1; c_exc = -1; fixlat = 1;
        for (int i = 0; i < 6; i++) tf[i] = -1;
        tf2 = -1; ir11 = -1; ir12 = -1;
        for (int i = 0; i < 13; i++) begin
            step();
            for (int j = 0; j < 6; j++) begin
                if (en[j]) begin
                    if (j == F && tf[F] >= 0 && tf2 < 0) tf2 = tcyc;
                    else if (tf[j] < 0) tf[j] = tcyc;
                end
            end
            if (tcyc == 11) ir11 = int'(instret);
            if (tcyc == 12) ir12 = int'(instret);
            respond();
        end
        chk("alu_fetch_t", tf[F], 1);
        chk("alu_decode_t", tf[D], 4);
        chk("alu_exec_t", tf[E], 7);
        chk("alu_write_t", tf[W], 10);
        chk("alu_no_mem", tf[M], -1);
        chk("alu_no_trap", tf[T], -1);
        chk("alu_instret11", ir11, 0);
        chk("alu_instret12", ir12, 1);
        chk("alu_fetch2_t", tf2, 13);

        // Randomized instruction stream against the stage-sequence model.
        do_reset();
        fixlat = 0;
        q.delete();
        q.push_back(F);
        idle = 0; hcnt = 0; ninstr = 0; model_ret = 0; in_halt = 0;
        for (int cyc = 0; cyc < 8000 && ninstr < 80; cyc++) begin
            step();
            if ($countones(en) > 1) chk("onehot", $countones(en), 1);
            if (en != 0) begin
                idle = 0;
                s = 0;
                for (int i = 5; i >= 0; i--) if (en[i]) s = i;
                if (in_halt && halt_req) chk("halt_early", en, 0);
                in_halt = 0;
                while (q.size() > 0 && q[0] == R) begin
                    void'(q.pop_front());
                    model_ret++;
                end
                e = (q.size() > 0) ? q.pop_front() : -1;
                chk("stage", s, e);
                chk("instret", instret, model_ret);
                chk("halted_low", halted, 0);
                if (s == F) begin
                    plan(ninstr);
                    ninstr++;
                end
            end else if (halted && !in_halt) begin
                idle = 0;
                in_halt = 1;
                while (q.size() > 0 && q[0] == R) begin
                    void'(q.pop_front());
                    model_ret++;
                end
                e = (q.size() > 0) ? q.pop_front() : -1;
                chk("halt_entry", H, e);
                chk("halt_instret", instret, model_ret);
                hcnt = int'($urandom_range(6, 1));
            end else if (in_halt) begin
                idle = 0;
                if (hcnt > 0) begin
                    hcnt--;
                    if (hcnt == 0) halt_req = 1'b0;
                end
            end else begin
                idle++;
                if (idle > 30) begin
                    chk("watchdog", idle, 0);
                    break;
                end
            end
            respond();
        end
        chk("rand_count", ninstr, 80);
        chk("rand_cycle", cycle, tcyc);

        // Reset while waiting on exec: everything clears at once.
        halt_req = 1'b0;
        interrupt_pending = 1'b0;
        stuck[E] = 1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (en[E]) found = 1;
            respond();
        end
        chk("exec_reached", found, 1);
        step(); respond();
        step(); respond();
        rstn = 1'b0;
        #1;
        chk("mid_rst_en", en, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_hang", hang, 0);
        chk("mid_rst_cycle", cycle, 0);
        chk("mid_rst_instret", instret, 0);
        resp_clear();
        stuck[E] = 0;
        fixlat = 1;
        @(negedge clk);
        rstn = 1'b1;
        tcyc = 0;
        step();
        chk("post_rst_fetch", en, 6'b000001);
        respond();
        step(); respond();
        step(); respond();
        step();
        chk("post_rst_decode", en, 6'b000010);
        respond();

        // Stuck mem stage: hang exactly TIMEOUT cycles after the pulse falls.
        do_reset();
        c_ld = 1; c_st = 0; c_a = 0; c_wr = 1; c_exc = -1; fixlat = 1;
        stuck[M] = 1;
        k = -1; late = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (en[M] && k < 0) k = tcyc;
            else if (k >= 0 && en != 0) late++;
            if (k >= 0 && tcyc == k + TO) chk("hang_early", hang, 0);
            if (k >= 0 && tcyc == k + TO + 1) chk("hang_set", hang, 1);
            respond();
        end
        chk("mem_pulse_t", k, 10);
        chk("hang_sticky", hang, 1);
        chk("hung_no_enables", late, 0);
        chk("hung_cycle", cycle, tcyc);
        chk("hung_instret", instret, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
